// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic row feeder, FIFO and PE blocks.
package systolic_feeder_pkg;

  localparam int unsigned DwDefault = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSkew = 2'd1,
    StData = 2'd2,
    StDone = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/systolic_feeder_if.sv
// Write side of a row input FIFO: strobe and data from the feeder, full and stall back.
interface systolic_feeder_if
  import systolic_feeder_pkg::*;
#(
    parameter int unsigned DW = DwDefault
);

    logic          fifo_we;
    logic [DW-1:0] fifo_din;
    logic          fifo_ff;
    logic          fifo_is;

    modport master(output fifo_we, output fifo_din, input fifo_ff, input fifo_is);
    modport slave(input fifo_we, input fifo_din, output fifo_ff, output fifo_is);

endinterface

// File: rtl/feeder_hold.sv
// One-entry hold register that absorbs the buffer read latency under FIFO backpressure.
module feeder_hold
  import systolic_feeder_pkg::*;
#(
    parameter int unsigned DW = DwDefault
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_issue,
    input  logic [DW-1:0] rdata,
    input  logic          pop,
    output logic          avail,
    output logic [DW-1:0] dout
);

    logic          pend_q;
    logic          valid_q;
    logic [DW-1:0] data_q;

    // Read data is usable in its arrival cycle; it is parked only if not popped then.
    assign avail = pend_q | valid_q;
    assign dout  = valid_q ? data_q : rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            pend_q <= rd_issue;
            if (pend_q && !pop) begin
                valid_q <= 1'b1;
                data_q  <= rdata;
            end else if (valid_q && pop) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Row edge injector: pushes skew zero words, then a buffered operand vector, into the row FIFO.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
    parameter int unsigned DW = DwDefault,
    parameter int unsigned AW = 3,
    parameter int unsigned SW = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [AW:0]              len,
    input  logic [SW-1:0]            skew,
    output logic                     busy,
    output logic                     done,
    output logic                     buf_re,
    output logic [AW-1:0]            buf_radr,
    input  logic [DW-1:0]            buf_rdata,
    systolic_feeder_if.master        fifo
);

    localparam logic [AW:0] FullLen = {1'b1, {AW{1'b0}}};

    feeder_state_e state_q;
    logic [AW:0]   len_q, rcnt_q, wcnt_q;
    logic [SW-1:0] skew_q, zcnt_q;
    logic [AW-1:0] radr_q;
    logic          busy_q, done_q;
    logic          hold_avail, push, rd_en, last_zero, last_word, ready;
    logic [DW-1:0] hold_dout;

    feeder_hold #(.DW(DW)) u_hold (
        .clk      (clk),
        .rst      (rst),
        .rd_issue (rd_en),
        .rdata    (buf_rdata),
        .pop      (push && (state_q == StData)),
        .avail    (hold_avail),
        .dout     (hold_dout)
    );

    always_comb begin
        push      = 1'b0;
        rd_en     = 1'b0;
        ready     = !fifo.fifo_ff && !fifo.fifo_is;
        last_zero = (zcnt_q == skew_q - 1'b1);
        last_word = (wcnt_q == len_q - 1'b1);
        case (state_q)
            StSkew: begin
                push  = ready;
                // Prefetch word 0 on the final zero so DATA starts without a bubble.
                rd_en = push && last_zero;
            end
            StData: begin
                push  = hold_avail && ready;
                rd_en = (!hold_avail || push) && (rcnt_q < len_q);
            end
            default: ;
        endcase
    end

    assign fifo.fifo_we  = push;
    assign fifo.fifo_din = (state_q == StData) ? hold_dout : '0;
    assign buf_re        = rd_en;
    assign buf_radr      = radr_q;
    assign busy          = busy_q;
    assign done          = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            len_q   <= '0;
            skew_q  <= '0;
            zcnt_q  <= '0;
            rcnt_q  <= '0;
            wcnt_q  <= '0;
            radr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (rd_en) begin
                rcnt_q <= rcnt_q + 1'b1;
                radr_q <= radr_q + 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (start) begin
                        len_q   <= (len == '0) ? FullLen : len;
                        skew_q  <= skew;
                        zcnt_q  <= '0;
                        rcnt_q  <= '0;
                        wcnt_q  <= '0;
                        radr_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= (skew == '0) ? StData : StSkew;
                    end
                end
                StSkew: begin
                    if (push) begin
                        zcnt_q <= zcnt_q + 1'b1;
                        if (last_zero) state_q <= StData;
                    end
                end
                StData: begin
                    if (push) begin
                        wcnt_q <= wcnt_q + 1'b1;
                        if (last_word) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
